// File: rtl/lm_encoder.sv
// ---------------------------------------------------------------------------
// lm_encoder
// Write side of the LED manager FIFO. Event pulses from N_SRC client modules
// are latched per source, arbitrated round-robin and pushed into the FIFO as
// one word per event: {1'b1 marker, zero pad, source id, event code}. The
// marker bit keeps a written word from ever showing as all-LEDs-off.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   src_valid  in   [N_SRC]          one-cycle event pulse per source
//   src_code   in   [N_SRC*CODE_W]   event codes, source i at [i*CODE_W +: CODE_W]
//   fifo_full  in   FIFO cannot accept a write
//   wr_en      out  FIFO write strobe (registered, one cycle per word)
//   wr_data    out  [WIDTH]          FIFO write data (registered, holds last word)
//   ovf_clr    in   clears ovf_flag / ovf_cnt
//   ovf_flag   out  sticky: at least one event was dropped
//   ovf_cnt    out  [CNT_W]          dropped-event count, saturating
// ---------------------------------------------------------------------------
module lm_encoder #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned SRC_W   = 2,
    parameter int unsigned CODE_W  = 4,
    parameter int unsigned MIN_GAP = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [N_SRC*CODE_W-1:0]   src_code,
    input  logic                      fifo_full,
    output logic                      wr_en,
    output logic [WIDTH-1:0]          wr_data,
    input  logic                      ovf_clr,
    output logic                      ovf_flag,
    output logic [CNT_W-1:0]          ovf_cnt
);

    localparam int unsigned DROP_W   = $clog2(N_SRC + 1);
    localparam int unsigned SUM_W    = CNT_W + DROP_W;
    localparam int unsigned GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int unsigned GAP_LOAD = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_GAP
    } state_e;

    state_e                    state_q, state_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic [N_SRC-1:0]          pend_q, pend_d;
    logic [N_SRC*CODE_W-1:0]   code_q, code_d;
    logic [SRC_W-1:0]          rr_q, rr_d;
    logic                      wr_en_q, wr_en_d;
    logic [WIDTH-1:0]          wr_data_q, wr_data_d;
    logic                      ovf_flag_q, ovf_flag_d;
    logic [CNT_W-1:0]          ovf_cnt_q, ovf_cnt_d;

    logic                      found;
    logic [SRC_W-1:0]          gnt_id;
    logic                      can_grant;
    logic                      grant;
    logic [DROP_W-1:0]         drops;
    logic [CNT_W-1:0]          ovf_base;
    logic [SUM_W-1:0]          ovf_sum;

    function automatic logic [SRC_W-1:0] wrap_idx(input int unsigned v);
        return SRC_W'(v % N_SRC);
    endfunction

    // Round-robin search: first pending source at or after rr_q, wrapping.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (!found && pend_q[wrap_idx(32'(rr_q) + k)]) begin
                found  = 1'b1;
                gnt_id = wrap_idx(32'(rr_q) + k);
            end
        end
    end

    // The last gap cycle may already grant so the next strobe lands exactly
    // MIN_GAP+1 cycles after the previous one.
    assign can_grant = (state_q == S_IDLE)
                    || ((state_q == S_WRITE) && (MIN_GAP == 0))
                    || ((state_q == S_GAP) && (gap_q == '0));
    assign grant     = can_grant && found && !fifo_full;

    // FSM next state
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (grant) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (MIN_GAP == 0) begin
                    state_d = grant ? S_WRITE : S_IDLE;
                end else begin
                    state_d = S_GAP;
                    gap_d   = GAP_W'(GAP_LOAD);
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = grant ? S_WRITE : S_IDLE;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Event capture / drop accounting. A source granted this edge frees its
    // slot, so a simultaneous new pulse on it is captured instead of dropped.
    always_comb begin
        pend_d = pend_q;
        code_d = code_q;
        drops  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (grant && (gnt_id == SRC_W'(i))) pend_d[i] = 1'b0;
            if (src_valid[i]) begin
                if (!pend_q[i] || (grant && (gnt_id == SRC_W'(i)))) begin
                    pend_d[i]                     = 1'b1;
                    code_d[i*CODE_W +: CODE_W]    = src_code[i*CODE_W +: CODE_W];
                end else begin
                    drops = drops + DROP_W'(1);
                end
            end
        end
    end

    // Clear applies first, then this cycle's drops are added (saturating).
    always_comb begin
        ovf_base   = ovf_clr ? '0 : ovf_cnt_q;
        ovf_sum    = SUM_W'(ovf_base) + SUM_W'(drops);
        ovf_cnt_d  = (ovf_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : ovf_sum[CNT_W-1:0];
        ovf_flag_d = (ovf_flag_q && !ovf_clr) || (drops != '0);
    end

    // Output word and pointer update
    always_comb begin
        wr_en_d   = grant;
        wr_data_d = wr_data_q;
        rr_d      = rr_q;
        if (grant) begin
            wr_data_d                  = '0;
            wr_data_d[WIDTH-1]         = 1'b1;
            wr_data_d[CODE_W +: SRC_W] = gnt_id;
            wr_data_d[0 +: CODE_W]     = code_q[32'(gnt_id)*CODE_W +: CODE_W];
            rr_d                       = wrap_idx(32'(gnt_id) + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gap_q      <= '0;
            pend_q     <= '0;
            code_q     <= '0;
            rr_q       <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            ovf_flag_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            pend_q     <= pend_d;
            code_q     <= code_d;
            rr_q       <= rr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            ovf_flag_q <= ovf_flag_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign ovf_flag = ovf_flag_q;
    assign ovf_cnt  = ovf_cnt_q;

endmodule

// File: tb/tb_lm_encoder.sv
// ---------------------------------------------------------------------------
// tb_lm_encoder
// Two encoders: u_a with back-to-back writes, u_b with a 3-cycle write gap.
// Stimulus pushes {word, cycle} expectations into per-DUT queues; a negedge
// monitor per DUT pops and compares whenever wr_en is high.
// ---------------------------------------------------------------------------
module tb_lm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  a_src_valid, b_src_valid;
    logic [15:0] a_src_code,  b_src_code;
    logic        a_fifo_full, b_fifo_full;
    logic        a_ovf_clr,   b_ovf_clr;
    logic        a_wr_en,     b_wr_en;
    logic [7:0]  a_wr_data,   b_wr_data;
    logic        a_ovf_flag,  b_ovf_flag;
    logic [7:0]  a_ovf_cnt,   b_ovf_cnt;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lm_encoder #(.WIDTH(8), .N_SRC(4), .SRC_W(2), .CODE_W(4), .MIN_GAP(0), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .src_valid(a_src_valid), .src_code(a_src_code),
        .fifo_full(a_fifo_full), .wr_en(a_wr_en), .wr_data(a_wr_data),
        .ovf_clr(a_ovf_clr), .ovf_flag(a_ovf_flag), .ovf_cnt(a_ovf_cnt)
    );

    lm_encoder #(.WIDTH(8), .N_SRC(4), .SRC_W(2), .CODE_W(4), .MIN_GAP(3), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .src_valid(b_src_valid), .src_code(b_src_code),
        .fifo_full(b_fifo_full), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .ovf_clr(b_ovf_clr), .ovf_flag(b_ovf_flag), .ovf_cnt(b_ovf_cnt)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input logic [7:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        qa.push_back(e);
    endtask

    task automatic expect_b(input logic [7:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        qb.push_back(e);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_wr_en) begin
            vectors++;
            if (qa.size() == 0) begin
                miscompares++;
                $display("FAIL a_unexpected_write: got %h at cyc %0d, want no write", a_wr_data, cyc);
            end else begin
                e = qa.pop_front();
                if (a_wr_data !== e.data || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL a_write: got %h at cyc %0d, want %h at cyc %0d",
                             a_wr_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_wr_en) begin
            vectors++;
            if (qb.size() == 0) begin
                miscompares++;
                $display("FAIL b_unexpected_write: got %h at cyc %0d, want no write", b_wr_data, cyc);
            end else begin
                e = qb.pop_front();
                if (b_wr_data !== e.data || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL b_write: got %h at cyc %0d, want %h at cyc %0d",
                             b_wr_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        int c;
        exp_t e;
        rst = 1'b1;
        a_src_valid = '0; a_src_code = '0; a_fifo_full = 1'b0; a_ovf_clr = 1'b0;
        b_src_valid = '0; b_src_code = '0; b_fifo_full = 1'b0; b_ovf_clr = 1'b0;
        tick;
        tick;

        // Reset state
        check("rst_wr_en",    a_wr_en,    0);
        check("rst_wr_data",  a_wr_data,  0);
        check("rst_ovf_flag", a_ovf_flag, 0);
        check("rst_ovf_cnt",  a_ovf_cnt,  0);
        check("rst_b_wr_en",  b_wr_en,    0);
        rst = 1'b0;
        tick;

        // Single event, latency 2, encoding 1_0_10_1010
        a_src_valid = 4'b0100; a_src_code = 16'h0A00;
        expect_a(8'hAA, cyc + 2);
        tick;
        a_src_valid = '0; a_src_code = '0;
        repeat (4) tick;
        check("hold_wr_data", a_wr_data, 8'hAA);
        check("hold_wr_en",   a_wr_en,   0);
        check("t1_ovf_cnt",   a_ovf_cnt, 0);

        // Burst of four, then src0 re-fires in its own grant cycle
        do_reset;
        a_src_valid = 4'hF; a_src_code = 16'h4321;
        c = cyc;
        expect_a(8'h81, c + 2);
        expect_a(8'h92, c + 3);
        expect_a(8'hA3, c + 4);
        expect_a(8'hB4, c + 5);
        expect_a(8'h85, c + 6);
        tick;
        a_src_valid = 4'h1; a_src_code = 16'h0005;
        tick;
        a_src_valid = '0; a_src_code = '0;
        repeat (6) tick;
        check("burst_ovf_cnt",  a_ovf_cnt,  0);
        check("burst_ovf_flag", a_ovf_flag, 0);

        // Lone id 0 event with rr pointer at 1 -> wraps to 0
        a_src_valid = 4'h1; a_src_code = 16'h0006;
        expect_a(8'h86, cyc + 2);
        tick;
        a_src_valid = '0; a_src_code = '0;
        repeat (4) tick;

        // FIFO full, src1 pulsed three times
        a_fifo_full = 1'b1;
        a_src_valid = 4'h2; a_src_code = 16'h0070;
        tick;
        a_src_code = 16'h0080;
        tick;
        a_src_code = 16'h0090;
        tick;
        a_src_valid = '0; a_src_code = '0;
        check("full_ovf_cnt",  a_ovf_cnt,  2);
        check("full_ovf_flag", a_ovf_flag, 1);
        repeat (3) tick;
        a_fifo_full = 1'b0;
        expect_a(8'h97, cyc + 1);
        tick;
        repeat (3) tick;
        a_ovf_clr = 1'b1;
        tick;
        a_ovf_clr = 1'b0;
        check("clr_ovf_cnt",  a_ovf_cnt,  0);
        check("clr_ovf_flag", a_ovf_flag, 0);

        // Clear and drop in the same cycle: the drop survives the clear
        a_fifo_full = 1'b1;
        a_src_valid = 4'h1; a_src_code = 16'h0001;
        tick;
        a_src_code = 16'h0002; a_ovf_clr = 1'b1;
        tick;
        a_src_valid = '0; a_src_code = '0; a_ovf_clr = 1'b0;
        check("clrdrop_ovf_cnt",  a_ovf_cnt,  1);
        check("clrdrop_ovf_flag", a_ovf_flag, 1);
        repeat (2) tick;
        a_fifo_full = 1'b0;
        expect_a(8'h81, cyc + 1);
        tick;
        repeat (3) tick;
        a_ovf_clr = 1'b1;
        tick;
        a_ovf_clr = 1'b0;

        // Saturation: 63 cycles x 4 drops = 252, then 256 -> FF, then stays
        a_fifo_full = 1'b1;
        a_src_code  = 16'hDCBA;
        repeat (64) begin
            a_src_valid = 4'hF;
            tick;
        end
        check("sat_ovf_cnt_252", a_ovf_cnt, 8'hFC);
        tick;
        check("sat_ovf_cnt_ff", a_ovf_cnt, 8'hFF);
        tick;
        check("sat_ovf_cnt_hold", a_ovf_cnt, 8'hFF);
        check("sat_ovf_flag",     a_ovf_flag, 1);
        a_src_valid = '0; a_src_code = '0;
        repeat (2) tick;
        a_fifo_full = 1'b0;
        c = cyc;
        expect_a(8'h9B, c + 1);
        expect_a(8'hAC, c + 2);
        expect_a(8'hBD, c + 3);
        expect_a(8'h8A, c + 4);
        tick;
        repeat (6) tick;

        // Reset while writing with three still pending
        a_fifo_full = 1'b1;
        a_src_valid = 4'hF; a_src_code = 16'h4321;
        tick;
        a_src_valid = '0; a_src_code = '0;
        tick;
        a_fifo_full = 1'b0;
        expect_a(8'h92, cyc + 1);
        tick;
        rst = 1'b1;
        tick;
        check("rstmid_wr_en", a_wr_en, 0);
        rst = 1'b0;
        repeat (8) tick;
        check("rstmid_ovf_cnt",  a_ovf_cnt,  0);
        check("rstmid_ovf_flag", a_ovf_flag, 0);

        // MIN_GAP=3: strobes exactly 4 cycles apart
        b_src_valid = 4'b0111; b_src_code = 16'h0321;
        c = cyc;
        expect_b(8'h81, c + 2);
        expect_b(8'h92, c + 6);
        expect_b(8'hA3, c + 10);
        tick;
        b_src_valid = '0; b_src_code = '0;
        repeat (14) tick;

        while (qa.size() > 0) begin
            e = qa.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL a_missing_write: got none, want %h at cyc %0d", e.data, e.cyc);
        end
        while (qb.size() > 0) begin
            e = qb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL b_missing_write: got none, want %h at cyc %0d", e.data, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
